updown_counter_param: RTL
=========================

Name: updown_counter_param

Overview:
- Parametrised successor to the team's fixed 4-bit 0..15 ping-pong counter.
- Generalised in width, with run-time lower/upper limits, four counting modes, enable, synchronous load, direction output and a turn/wrap event pulse.
- Used as a pattern/address sequencer and as a stimulus source in lab exercises.

Parameters:
- WIDTH, 4: counter width in bits (2..16).
- TURN_HOLD, 1:
  - 1 = in BOUNCE mode the count dwells one enabled cycle at the limit while direction flips (legacy ping-pong timing).
  - 0 = the count reverses immediately.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  advance count this cycle when high.
- mode  input  2  00 UP_WRAP, 01 DOWN_WRAP, 10 BOUNCE, 11 HOLD.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value to load.
- lo_limit  input  WIDTH  lower count limit (inclusive).
- hi_limit  input  WIDTH  upper count limit (inclusive).
- count  output  WIDTH  registered count.
- dir  output  1  registered direction, 0 = up, 1 = down.
- event_pulse  output  1  registered; high for exactly one cycle after a wrap or turnaround step.
- at_lo  output  1  combinational, count == lo_limit.
- at_hi  output  1  combinational, count == hi_limit.
- limit_err  output  1  combinational, lo_limit > hi_limit.

Behaviour:
- All state updates on the rising clock edge. Priority: reset, then load, then enable.
- Reset (reset == 0 at an edge): count = 0, dir = 0, event_pulse = 0. Reset asserted mid-sequence aborts the sequence on that edge with no event.
- Load (load == 1):
  - If limit_err = 0, count = load_value clamped into [lo_limit, hi_limit].
  - If limit_err = 1, count = load_value unclamped.
  - dir unchanged; event_pulse = 0.
  - Load wins over enable in the same cycle.
- Step (enable == 1, load == 0, limit_err == 0), by mode:
  - UP_WRAP: dir = 0. If count >= hi_limit, count = lo_limit and event_pulse = 1; else count + 1.
  - DOWN_WRAP: dir = 1. If count <= lo_limit, count = hi_limit and event_pulse = 1; else count - 1.
  - BOUNCE, dir = 0: if count >= hi_limit, dir = 1 and event_pulse = 1; count holds if TURN_HOLD = 1, else count = count - 1 (holds if lo_limit == hi_limit). Otherwise count + 1.
  - BOUNCE, dir = 1: mirror of the above using lo_limit and +1.
  - HOLD: count and dir unchanged.
- No step: enable == 0 or limit_err == 1 leaves count and dir unchanged.
- event_pulse is 0 in every cycle not described above as setting it.
- Arithmetic: limit compares are performed before +/-1, so no modular overflow occurs at 0 or 2^WIDTH-1.
- Out-of-range count (after limits change at run time):
  - count above hi_limit: treated as "at or past" the upper limit by the >= compare.
  - count below lo_limit: treated as "at or past" the lower limit by the <= compare.
  - Otherwise the count steps normally toward the range.
- lo_limit == hi_limit: count pinned.
  - Wrap modes: event_pulse every enabled cycle.
  - BOUNCE: dir toggles and event_pulse fires every enabled cycle.
- Mode change: takes effect on the next enabled edge. Entering BOUNCE keeps the current dir; wrap modes force dir on their first step.
- Latency: count, dir and event_pulse reflect a step one cycle after the enabling edge. at_lo, at_hi and limit_err are combinational from the current register and inputs.

Test Plan:
- Reset and hold:
  - Stimulus: reset = 0 for 2 cycles with enable = 1, mode = 00.
  - Required response: count = 0, dir = 0, event_pulse = 0.
  - Then release reset with enable = 0 for 3 cycles: count stays 0.
- BOUNCE legacy timing:
  - Setup: WIDTH = 4, TURN_HOLD = 1, limits 0/15, enable = 1 from reset.
  - Required response: count 0..15, then 15 again with dir -> 1 and event_pulse = 1, then 14..0, then 0 again with dir -> 0.
  - Full period is 32 cycles.
- BOUNCE immediate reversal:
  - Setup: TURN_HOLD = 0, limits 3/6.
  - Required response: 3,4,5,6,5,4,3,4…; event_pulse asserted in the cycle after each transition into 5 from 6 and into 4 from 3.
- UP_WRAP and DOWN_WRAP:
  - UP_WRAP with limits 2/5: 2,3,4,5,2 with event_pulse on the cycle after the wrap.
  - Switch to DOWN_WRAP at count 4: 3,2,5,4…; dir = 1.
- Load, clamp and priority:
  - Limits 4/9, load = 1, enable = 1, load_value = 12: count = 9, no event.
  - load_value = 1: count = 4.
  - reset = 0 together with load = 1: count = 0.
- Error and pinned cases:
  - lo = 8, hi = 3: limit_err = 1, enable has no effect, load of 1 gives count = 1.
  - Then lo = hi = 7 in BOUNCE after loading 7: count stays 7, dir toggles and event_pulse fires every cycle.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down/bounce counter with run-time limits, load, and a
// registered wrap/turnaround event pulse.
module updown_counter_param #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          TURN_HOLD = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             event_pulse,
  output logic             at_lo,
  output logic             at_hi,
  output logic             limit_err
);

  localparam logic [1:0] ModeUpWrap   = 2'b00;
  localparam logic [1:0] ModeDownWrap = 2'b01;
  localparam logic [1:0] ModeBounce   = 2'b10;
  localparam logic [1:0] ModeHold     = 2'b11;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             event_q, event_d;
  logic [WIDTH-1:0] load_clamped;
  logic             past_hi, past_lo, pinned;

  assign limit_err = lo_limit > hi_limit;
  assign at_lo     = count_q == lo_limit;
  assign at_hi     = count_q == hi_limit;
  // Limit compares happen before +/-1, so no modular overflow at the range ends.
  assign past_hi   = count_q >= hi_limit;
  assign past_lo   = count_q <= lo_limit;
  assign pinned    = lo_limit == hi_limit;

  always_comb begin
    load_clamped = load_value;
    if (load_value < lo_limit) begin
      load_clamped = lo_limit;
    end else if (load_value > hi_limit) begin
      load_clamped = hi_limit;
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    event_d = 1'b0;
    if (load) begin
      count_d = limit_err ? load_value : load_clamped;
    end else if (enable && !limit_err) begin
      unique case (mode)
        ModeUpWrap: begin
          dir_d = 1'b0;
          if (past_hi) begin
            count_d = lo_limit;
            event_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        ModeDownWrap: begin
          dir_d = 1'b1;
          if (past_lo) begin
            count_d = hi_limit;
            event_d = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        ModeBounce: begin
          if (!dir_q) begin
            if (past_hi) begin
              dir_d   = 1'b1;
              event_d = 1'b1;
              if (!TURN_HOLD && !pinned) count_d = count_q - WIDTH'(1);
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            if (past_lo) begin
              dir_d   = 1'b0;
              event_d = 1'b1;
              if (!TURN_HOLD && !pinned) count_d = count_q + WIDTH'(1);
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        ModeHold: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      event_q <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      event_q <= event_d;
    end
  end

  assign count       = count_q;
  assign dir         = dir_q;
  assign event_pulse = event_q;

endmodule
